stage_execute: RTL and testbench

STAGE_EXECUTE -- requirements
Module: stage_execute

---
 rtl/stage_execute.sv | 177 +++++++++++++++++
 tb/tb_stage_execute.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_execute.sv
// stage_execute: single-issue execute stage. Integer ALU ops finish in one cycle.
// Optional feature macro EXECUTE_MULDIV_EN adds an iterative MUL/DIVU/REMU unit
// (IDLE/BUSY/DONE sequencer, 33 cycles per op). Without it, ops 11-13 are
// reserved and execute_stall is tied low.
module stage_execute (
   input  logic        clk,
   input  logic        rst,
   input  logic        decode_valid,
   input  logic [4:0]  decode_rd,
   input  logic [31:0] decode_rs1_data,
   input  logic [31:0] decode_rs2_data,
   input  logic [31:0] decode_imm,
   input  logic        decode_alu_src,
   input  logic [3:0]  decode_alu_op,
   input  logic        decode_mem_to_reg,
   input  logic        decode_wr_enable,
   input  logic        flush,
   output logic        execute_stall,
   output logic        execute_valid,
   output logic [4:0]  execute_rd,
   output logic [31:0] execute_alu_result,
   output logic        execute_mem_to_reg,
   output logic        execute_wr_enable
);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_SLL    = 4'd2;
   localparam logic [3:0] OP_SLT    = 4'd3;
   localparam logic [3:0] OP_SLTU   = 4'd4;
   localparam logic [3:0] OP_XOR    = 4'd5;
   localparam logic [3:0] OP_SRL    = 4'd6;
   localparam logic [3:0] OP_SRA    = 4'd7;
   localparam logic [3:0] OP_OR     = 4'd8;
   localparam logic [3:0] OP_AND    = 4'd9;
   localparam logic [3:0] OP_PASS_B = 4'd10;

   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [4:0]  shamt;
   logic [31:0] simple_result;
   logic        simple_known;
   logic        simple_issue;   // a single-cycle instruction is taken this edge
   logic        muldiv_done;    // the iterative unit hands over its result this edge
   logic [31:0] muldiv_result;

   assign operand_a = decode_rs1_data;
   assign operand_b = decode_alu_src ? decode_imm : decode_rs2_data;
   assign shamt     = operand_b[4:0];

   // Single-cycle ALU; unknown op codes give 0 and suppress the register write.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      simple_result = '0;
      simple_known  = 1'b1;
      case (decode_alu_op)
         OP_ADD:    simple_result = operand_a + operand_b;
         OP_SUB:    simple_result = operand_a - operand_b;
         OP_SLL:    simple_result = operand_a << shamt;
         OP_SLT:    simple_result = {31'd0, $signed(operand_a) < $signed(operand_b)};
         OP_SLTU:   simple_result = {31'd0, operand_a < operand_b};
         OP_XOR:    simple_result = operand_a ^ operand_b;
         OP_SRL:    simple_result = operand_a >> shamt;
         OP_SRA:    simple_result = $unsigned($signed(operand_a) >>> shamt);
         OP_OR:     simple_result = operand_a | operand_b;
         OP_AND:    simple_result = operand_a & operand_b;
         OP_PASS_B: simple_result = operand_b;
         default:   simple_known  = 1'b0;
      endcase
   end

   // Output register: flush kills, a finished multi-cycle op drains, else the 1-cycle path.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only; reset clears every output.
      if (rst) begin
         execute_valid      <= 1'b0;
         execute_rd         <= '0;
         execute_alu_result <= '0;
         execute_mem_to_reg <= 1'b0;
         execute_wr_enable  <= 1'b0;
      end else if (flush) begin
         execute_valid      <= 1'b0;
         execute_wr_enable  <= 1'b0;
      end else if (muldiv_done) begin
         execute_valid      <= 1'b1;
         execute_rd         <= decode_rd;
         execute_alu_result <= muldiv_result;
         execute_mem_to_reg <= decode_mem_to_reg;
         execute_wr_enable  <= decode_wr_enable;
      end else if (simple_issue) begin
         execute_valid      <= 1'b1;
         execute_rd         <= decode_rd;
         execute_alu_result <= simple_result;
         execute_mem_to_reg <= decode_mem_to_reg;
         execute_wr_enable  <= decode_wr_enable & simple_known;
      end else begin
         execute_valid      <= 1'b0;
         execute_wr_enable  <= 1'b0;
      end
   end

`ifdef EXECUTE_MULDIV_EN
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;
   localparam logic [3:0] OP_REMU = 4'd13;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic [1:0] {MODE_MUL, MODE_DIVU, MODE_REMU} mode_e;

   state_e      state;
   mode_e       mode;
   logic [4:0]  count;
   logic [31:0] op_a;        // multiplicand (shifted left) or dividend/quotient
   logic [31:0] op_b;        // multiplier (shifted right) or divisor
   logic [31:0] acc;         // product accumulator or partial remainder
   logic        is_muldiv;
   logic [32:0] trial_diff;  // bit 32 is the borrow of the restoring step

   assign is_muldiv     = (decode_alu_op == OP_MUL) || (decode_alu_op == OP_DIVU) ||
                          (decode_alu_op == OP_REMU);
   assign trial_diff    = {acc, op_a[31]} - {1'b0, op_b};
   assign execute_stall = (state == BUSY) || ((state == IDLE) && decode_valid && is_muldiv);
   assign simple_issue  = (state == IDLE) && decode_valid && !is_muldiv;
   assign muldiv_done   = (state == DONE);
   assign muldiv_result = (mode == MODE_DIVU) ? op_a : acc;

   // Iterative sequencer: one multiply or divide bit per cycle for 32 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mode  <= MODE_MUL;
         count <= '0;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
      end else if (flush) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (decode_valid && is_muldiv) begin
                  op_a  <= operand_a;
                  op_b  <= operand_b;
                  acc   <= '0;
                  count <= '0;
                  mode  <= (decode_alu_op == OP_MUL)  ? MODE_MUL  :
                           (decode_alu_op == OP_DIVU) ? MODE_DIVU : MODE_REMU;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (mode == MODE_MUL) begin
                  if (op_b[0]) acc <= acc + op_a;
                  op_a <= op_a << 1;
                  op_b <= op_b >> 1;
               end else begin
                  // Divide by zero never borrows: quotient fills with ones, remainder = dividend.
                  op_a <= {op_a[30:0], !trial_diff[32]};
                  acc  <= trial_diff[32] ? {acc[30:0], op_a[31]} : trial_diff[31:0];
               end
               count <= count + 5'd1;
               if (count == 5'd31) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign execute_stall = 1'b0;
   assign simple_issue  = decode_valid;
   assign muldiv_done   = 1'b0;
   assign muldiv_result = '0;
`endif

endmodule

// File: tb/tb_stage_execute.sv
// tb_stage_execute: randomized scoreboard bench for stage_execute. The driver
// pushes the expected output record when an instruction is consumed; a monitor
// pops and compares whenever execute_valid is seen. Follows EXECUTE_MULDIV_EN.
module tb_stage_execute;

   logic        clk = 1'b0;
   logic        rst;
   logic        decode_valid;
   logic [4:0]  decode_rd;
   logic [31:0] decode_rs1_data;
   logic [31:0] decode_rs2_data;
   logic [31:0] decode_imm;
   logic        decode_alu_src;
   logic [3:0]  decode_alu_op;
   logic        decode_mem_to_reg;
   logic        decode_wr_enable;
   logic        flush;
   logic        execute_stall;
   logic        execute_valid;
   logic [4:0]  execute_rd;
   logic [31:0] execute_alu_result;
   logic        execute_mem_to_reg;
   logic        execute_wr_enable;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] result;
      logic        m2r;
      logic        we;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   stage_execute dut (
      .clk                (clk),
      .rst                (rst),
      .decode_valid       (decode_valid),
      .decode_rd          (decode_rd),
      .decode_rs1_data    (decode_rs1_data),
      .decode_rs2_data    (decode_rs2_data),
      .decode_imm         (decode_imm),
      .decode_alu_src     (decode_alu_src),
      .decode_alu_op      (decode_alu_op),
      .decode_mem_to_reg  (decode_mem_to_reg),
      .decode_wr_enable   (decode_wr_enable),
      .flush              (flush),
      .execute_stall      (execute_stall),
      .execute_valid      (execute_valid),
      .execute_rd         (execute_rd),
      .execute_alu_result (execute_alu_result),
      .execute_mem_to_reg (execute_mem_to_reg),
      .execute_wr_enable  (execute_wr_enable)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour straight from the op table, using plain arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic src, input logic [4:0] rd,
                                  input logic m2r, input logic we);
      exp_t        e;
      logic [31:0] b;
      int          sh;
      logic        known;
      b     = src ? imm : rs2;
      sh    = int'(b % 32);
      known = 1'b1;
      e.result = 32'd0;
      case (op)
         4'd0:  e.result = a + b;
         4'd1:  e.result = a - b;
         4'd2:  e.result = a * (32'd1 << sh);
         4'd3:  e.result = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd4:  e.result = (a < b) ? 32'd1 : 32'd0;
         4'd5:  e.result = a ^ b;
         4'd6:  e.result = a / (32'd1 << sh);
         4'd7:  e.result = (a / (32'd1 << sh)) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd8:  e.result = a | b;
         4'd9:  e.result = a & b;
         4'd10: e.result = b;
`ifdef EXECUTE_MULDIV_EN
         4'd11: e.result = a * b;
         4'd12: e.result = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd13: e.result = (b == 0) ? a : a % b;
`endif
         default: known = 1'b0;
      endcase
      e.rd  = rd;
      e.m2r = m2r;
      e.we  = known & we;
      return e;
   endfunction

   // Present one instruction, hold it while stalled, record the expectation when consumed.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic src, input logic [4:0] rd,
                        input logic m2r, input logic we, input logic fl, output int stalls);
      @(negedge clk);
      decode_valid      = 1'b1;
      decode_alu_op     = op;
      decode_rs1_data   = a;
      decode_rs2_data   = rs2;
      decode_imm        = imm;
      decode_alu_src    = src;
      decode_rd         = rd;
      decode_mem_to_reg = m2r;
      decode_wr_enable  = we;
      flush             = fl;
      stalls            = 0;
      if (fl) begin
         @(posedge clk);
      end else begin
         #1;
         while (execute_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
         end
         if (execute_stall) check("stall timeout", 32'd1, 32'd0);
         else exp_q.push_back(model(op, a, rs2, imm, src, rd, m2r, we));
         @(posedge clk);
      end
      #1;
      decode_valid = 1'b0;
      flush        = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compare every presented result against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (execute_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb result", execute_alu_result, e.result);
               check("sb rd", 32'(execute_rd), 32'(e.rd));
               check("sb wr_enable", 32'(execute_wr_enable), 32'(e.we));
               check("sb mem_to_reg", 32'(execute_mem_to_reg), 32'(e.m2r));
            end
         end else begin
            check("wr_enable while not valid", 32'(execute_wr_enable), 32'd0);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int st;
      rst = 1'b1;
      decode_valid = 1'b0; decode_rd = '0; decode_rs1_data = '0; decode_rs2_data = '0;
      decode_imm = '0; decode_alu_src = 1'b0; decode_alu_op = '0;
      decode_mem_to_reg = 1'b0; decode_wr_enable = 1'b0; flush = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset valid", 32'(execute_valid), 32'd0);
      check("reset wr_enable", 32'(execute_wr_enable), 32'd0);
      check("reset mem_to_reg", 32'(execute_mem_to_reg), 32'd0);
      check("reset rd", 32'(execute_rd), 32'd0);
      check("reset result", execute_alu_result, 32'd0);
      rst = 1'b0;
      #1;
      check("stall after reset", 32'(execute_stall), 32'd0);

      // ADD wraps into the sign bit.
      issue(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h1234, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, st);
      @(negedge clk);
      check("ADD overflow result", execute_alu_result, 32'h8000_0000);
      check("ADD valid", 32'(execute_valid), 32'd1);
      // Bubble: valid drops, result held.
      @(negedge clk);
      check("bubble valid", 32'(execute_valid), 32'd0);
      check("bubble holds result", execute_alu_result, 32'h8000_0000);

      // SRA uses only the low five bits of the immediate.
      issue(4'd7, 32'h8000_0000, 32'd0, 32'd33, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, st);
      @(negedge clk);
      check("SRA imm=33 result", execute_alu_result, 32'hC000_0000);

      // Reserved op: valid result of zero, no write.
      issue(4'd14, 32'hDEAD_BEEF, 32'd9, 32'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, st);
      @(negedge clk);
      check("reserved valid", 32'(execute_valid), 32'd1);
      check("reserved wr_enable", 32'(execute_wr_enable), 32'd0);
      check("reserved result", execute_alu_result, 32'd0);

      // Flush together with a new instruction discards it.
      issue(4'd0, 32'd5, 32'd6, 32'd0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, st);
      @(negedge clk);
      check("flush+valid discarded", 32'(execute_valid), 32'd0);

`ifdef EXECUTE_MULDIV_EN
      // MUL: 33 stall cycles, result visible for exactly one cycle.
      issue(4'd11, 32'h0001_0003, 32'h0000_0005, 32'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, st);
      check("MUL stall cycles", 32'(st), 32'd33);
      @(negedge clk);
      check("MUL result", execute_alu_result, 32'h0005_000F);
      check("MUL valid", 32'(execute_valid), 32'd1);
      @(negedge clk);
      check("MUL valid one cycle", 32'(execute_valid), 32'd0);

      issue(4'd12, 32'd100, 32'd0, 32'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, st);
      check("DIVU stall cycles", 32'(st), 32'd33);
      @(negedge clk);
      check("DIVU by zero", execute_alu_result, 32'hFFFF_FFFF);

      issue(4'd13, 32'd100, 32'd0, 32'd7, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, st);
      @(negedge clk);
      check("REMU 100%7", execute_alu_result, 32'd2);

      // Flush in the middle of a DIVU.
      @(negedge clk);
      decode_valid = 1'b1; decode_alu_op = 4'd12; decode_rs1_data = 32'd100;
      decode_rs2_data = 32'd7; decode_alu_src = 1'b0; decode_rd = 5'd8; decode_wr_enable = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("stall during flush cycle", 32'(execute_stall), 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      decode_valid = 1'b0;
      @(negedge clk);
      check("flush valid", 32'(execute_valid), 32'd0);
      check("flush stall released", 32'(execute_stall), 32'd0);
      issue(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, st);
      check("ADD after flush no stall", 32'(st), 32'd0);
      @(negedge clk);
      check("ADD after flush result", execute_alu_result, 32'd5);

      // Reset in the middle of a MUL.
      @(negedge clk);
      decode_valid = 1'b1; decode_alu_op = 4'd11; decode_rs1_data = 32'd9;
      decode_rs2_data = 32'd9; decode_rd = 5'd10; decode_mem_to_reg = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      decode_valid = 1'b0;
      decode_mem_to_reg = 1'b0;
      @(negedge clk);
      check("mid-BUSY reset valid", 32'(execute_valid), 32'd0);
      check("mid-BUSY reset result", execute_alu_result, 32'd0);
      check("mid-BUSY reset rd", 32'(execute_rd), 32'd0);
      check("mid-BUSY reset stall", 32'(execute_stall), 32'd0);
`else
      // Without the multiply/divide unit, MUL behaves as a reserved op.
      issue(4'd11, 32'h0001_0003, 32'h0000_0005, 32'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, st);
      check("MUL reserved no stall", 32'(st), 32'd0);
      @(negedge clk);
      check("MUL reserved valid", 32'(execute_valid), 32'd1);
      check("MUL reserved wr_enable", 32'(execute_wr_enable), 32'd0);
      check("MUL reserved result", execute_alu_result, 32'd0);
`endif

      // Randomized traffic with bubbles and occasional flushes.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
         end else begin
            issue(4'($urandom_range(0, 15)), rand_word(), rand_word(), rand_word(),
                  1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), st);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      // Final reset clears the outputs again.
      issue(4'd10, 32'd0, 32'hA5A5_0001, 32'd0, 1'b0, 5'd17, 1'b1, 1'b1, 1'b0, st);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("final reset result", execute_alu_result, 32'd0);
      check("final reset rd", 32'(execute_rd), 32'd0);
      check("final reset mem_to_reg", 32'(execute_mem_to_reg), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
